// File: rtl/fib_req_scheduler.sv
// fib_req_scheduler
//   Shares one iterative Fibonacci datapath (two W-bit registers and one adder)
//   among NREQ requesters. A round-robin arbiter grants one request at a time.
//   The block iterates n times and then returns F(n), the requester ID and an
//   overflow flag over a valid/ready response channel.
//
//   Build option: define FIB_SAT_EN to saturate resp_data to all ones whenever
//   the true F(n) does not fit in W bits. Without it, resp_data is F(n) mod 2^W.
//   resp_ovf is the same in both builds.
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   req_valid   [NREQ]     per-requester request valid
//   req_n       [NREQ*NW]  packed indices, requester i at [i*NW +: NW]
//   req_ready   [NREQ]     one-hot grant, only driven in IDLE
//   resp_valid  result available, held until resp_ready
//   resp_ready  consumer accepts the result
//   resp_id     [IDW]      requester the result belongs to
//   resp_data   [W]        F(n) (mod 2^W, or saturated with FIB_SAT_EN)
//   resp_ovf    true F(n) exceeded 2^W-1
//   busy        high in every state except IDLE
module fib_req_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int NW   = 8,
    parameter int W    = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*NW-1:0] req_n,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic              resp_ovf,
    output logic              busy
);

`ifdef FIB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [NW-1:0]   cnt;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            ovf_a;
    logic            ovf_b;
    logic [W:0]      sum;

    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  rr_nx;
    logic [NW-1:0]   gnt_n;

    function automatic logic [W-1:0] sat_result(input logic [W-1:0] v, input logic ovf);
        if (SAT_EN && ovf)
            return {W{1'b1}};
        return v;
    endfunction

    // Round-robin search: priority k=0 is the requester at rr_ptr, then upward
    // modulo NREQ. The inner loop keeps every bit select on a constant index.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        rr_nx   = '0;
        gnt_n   = '0;
        if (state == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!gnt_any && req_valid[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
                        gnt_any = 1'b1;
                        gnt[i]  = 1'b1;
                        gnt_id  = IDW'(i);
                        rr_nx   = IDW'((i + 1) % NREQ);
                        gnt_n   = req_n[i*NW +: NW];
                    end
                end
            end
        end
    end

    assign req_ready = gnt;
    assign busy      = (state != IDLE);

    // Carry-out of the shared adder feeds the overflow tracking of b.
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any)      state_nx = RUN;
            RUN:     if (cnt == '0)    state_nx = DONE;
            DONE:    if (resp_ready)   state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            cnt        <= '0;
            a          <= '0;
            b          <= '0;
            ovf_a      <= 1'b0;
            ovf_b      <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cur_id <= gnt_id;
                        cnt    <= gnt_n;
                        a      <= '0;
                        b      <= W'(1);
                        ovf_a  <= 1'b0;
                        ovf_b  <= 1'b0;
                        rr_ptr <= rr_nx;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        a     <= b;
                        b     <= sum[W-1:0];
                        // b can overflow while a is still exact, so each
                        // register carries its own flag and the result uses a.
                        ovf_a <= ovf_b;
                        ovf_b <= ovf_b | sum[W] | ovf_a;
                        cnt   <= cnt - NW'(1);
                    end else begin
                        resp_data  <= sat_result(a, ovf_a);
                        resp_ovf   <= ovf_a;
                        resp_id    <= cur_id;
                        resp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_req_scheduler.sv
module tb_fib_req_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int NW   = 8;
    localparam int W    = 20;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*NW-1:0] req_n = '0;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              resp_ovf;
    logic              busy;

    fib_req_scheduler #(.NREQ(NREQ), .IDW(IDW), .NW(NW), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           ovf;
        logic           chk_data;
        int             lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rv_prev = 1'b0;

`ifdef FIB_SAT_EN
    localparam logic [W-1:0] F31_DATA = 20'd1048575;
    localparam logic         F255_CHK = 1'b1;
`else
    localparam logic [W-1:0] F31_DATA = 20'd297693;
    localparam logic         F255_CHK = 1'b0;
`endif

    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            check("grant_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
            if (busy)
                check("ready_low_when_busy", {28'd0, req_ready}, 32'd0);
            if (|(req_valid & req_ready))
                acc_q.push_back(cyc + 1);
            if (resp_valid && !rv_prev) begin
                if (acc_q.size() == 0 || exp_q.size() == 0) begin
                    check("unexpected_resp_rise", 32'd1, 32'd0);
                end else begin
                    int acc;
                    acc = acc_q.pop_front();
                    check("latency", cyc - acc, exp_q[0].lat);
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_id", {30'd0, resp_id}, {30'd0, e.id});
                    check("resp_ovf", {31'd0, resp_ovf}, {31'd0, e.ovf});
                    if (e.chk_data)
                        check("resp_data", {12'd0, resp_data}, {12'd0, e.data});
                end
            end
            rv_prev = resp_valid;
        end
    end

    task automatic push_exp(input int id, input int data, input logic ovf,
                            input logic chk, input int lat);
        exp_t e;
        e.id = IDW'(id); e.data = W'(data); e.ovf = ovf; e.chk_data = chk; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Returns one step after the acceptance edge.
    task automatic wait_accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clock);
            if (req_valid[id] && req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic issue(input int id, input int n, input int data, input logic ovf,
                         input logic chk);
        push_exp(id, data, ovf, chk, n + 1);
        req_n[id*NW +: NW] = NW'(n);
        req_valid[id] = 1'b1;
        wait_accept(id);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(posedge clock); #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  {28'd0, req_ready}, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_id"},    {30'd0, resp_id}, 32'd0);
        check({tag, "_resp_data"},  {12'd0, resp_data}, 32'd0);
        check({tag, "_resp_ovf"},   {31'd0, resp_ovf}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check_all_zero("rst");

        // Single requests, small n
        issue(0, 5, 5, 1'b0, 1'b1);   wait_idle();
        issue(0, 0, 0, 1'b0, 1'b1);   wait_idle();
        issue(0, 1, 1, 1'b0, 1'b1);   wait_idle();

        // Overflow boundary
        issue(0, 30, 832040, 1'b0, 1'b1);   wait_idle();
        issue(0, 31, F31_DATA, 1'b1, 1'b1); wait_idle();
        issue(0, 255, 1048575, 1'b1, F255_CHK); wait_idle();

        // Bring the round-robin pointer back to 0
        issue(3, 2, 1, 1'b0, 1'b1);   wait_idle();

        // All four requesters valid continuously
        push_exp(0, 2, 1'b0, 1'b1, 4);
        push_exp(1, 3, 1'b0, 1'b1, 5);
        push_exp(2, 8, 1'b0, 1'b1, 7);
        push_exp(3, 13, 1'b0, 1'b1, 8);
        push_exp(0, 2, 1'b0, 1'b1, 4);
        req_n = {8'd7, 8'd6, 8'd4, 8'd3};
        req_valid = 4'hF;
        begin
            int acc_cnt;
            acc_cnt = 0;
            for (int t = 0; t < 400; t++) begin
                @(negedge clock);
                if (|(req_valid & req_ready)) acc_cnt++;
                if (acc_cnt == 5) break;
            end
            check("rr_accept_count", acc_cnt, 5);
        end
        @(posedge clock); #1;
        req_valid = '0;
        wait_idle();

        // Backpressure: n=10 from requester 1, consumer stalls 20 cycles
        resp_ready = 1'b0;
        issue(1, 10, 55, 1'b0, 1'b1);
        push_exp(3, 3, 1'b0, 1'b1, 5);
        req_n[3*NW +: NW] = 8'd4;
        req_valid[3] = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clock);
                if (resp_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check("bp_resp_timeout", 32'd1, 32'd0);
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_data", {12'd0, resp_data}, 32'd55);
            check("bp_id", {30'd0, resp_id}, 32'd1);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
        end
        @(posedge clock); #1 resp_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_idle_after_ack", {31'd0, busy}, 32'd0);
        check("bp_valid_dropped", {31'd0, resp_valid}, 32'd0);
        wait_accept(3);
        req_valid[3] = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of RUN
        push_exp(2, 6765, 1'b0, 1'b1, 21);
        req_n[2*NW +: NW] = 8'd20;
        req_valid[2] = 1'b1;
        wait_accept(2);
        req_valid[2] = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check_all_zero("async_rst");
        @(posedge clock); #1 reset = 1'b0;
        // Pointer must be back at 0: requesters 0 and 3 compete, 0 wins
        push_exp(0, 1, 1'b0, 1'b1, 3);
        req_n[0*NW +: NW] = 8'd2;
        req_n[3*NW +: NW] = 8'd2;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        wait_accept(0);
        req_valid = '0;
        wait_idle();

        // Input change after acceptance is ignored
        push_exp(0, 21, 1'b0, 1'b1, 9);
        req_n[0*NW +: NW] = 8'd8;
        req_valid[0] = 1'b1;
        wait_accept(0);
        req_n[0*NW +: NW] = 8'd12;
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_req_scheduler.md
Name: fib_req_scheduler

Overview:
- Shares one iterative Fibonacci datapath (two W-bit registers, one adder) among NREQ requesters.
- Each requester submits an index n over a valid/ready handshake.
- A round-robin arbiter grants one request at a time. The block sequences the iterations, then returns F(n) with the requester ID and an overflow flag over a valid/ready response channel.
- Sits between client blocks and the Fibonacci generator function, replacing free-running per-client generators.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- NW, 8, index width; n ranges 0..2^NW-1.
- W, 20, result width.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NREQ  per-requester request valid.
- req_n  in  NREQ*NW  packed indices; requester i occupies bits [i*NW +: NW].
- req_ready  out  NREQ  one-hot grant; at most one bit high.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  requester index the result belongs to.
- resp_data  out  W  F(n).
- resp_ovf  out  1  true F(n) exceeded 2^W-1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0, busy=0, state=IDLE, RR pointer=0.
- Reset mid-operation: the in-flight request is discarded and no response is issued.
- Fibonacci definition: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: one-hot grant to the first i with req_valid[i]=1, searching from RR pointer upward modulo NREQ.
  - req_ready=0 when no req_valid is high and in all non-IDLE states.
  - Acceptance: req_valid[i] & req_ready[i] at an edge.
  - On acceptance: latch id=i and cnt=req_n[i]; set a=0, b=1, ovf_a=0, ovf_b=0; RR pointer=(i+1) mod NREQ; go to RUN.
- RUN, cnt!=0:
  - Per cycle: a<=b; b<=a+b truncated to W bits; ovf_a<=ovf_b; ovf_b<=ovf_b | carry-out | ovf_a; cnt<=cnt-1.
- RUN, cnt==0:
  - Register resp_data=a, resp_ovf=ovf_a, resp_id=id, resp_valid=1; go to DONE.
- Latency: resp_valid rises exactly n+1 clocks after the acceptance edge.
- DONE:
  - Hold all resp_* outputs stable until resp_valid & resp_ready at an edge.
  - Then resp_valid<=0; go to IDLE.
  - resp_data/resp_id/resp_ovf retain their last values afterwards.
- Minimum spacing between acceptances: n+3 cycles when resp_ready is held high.
- Requester inputs:
  - Changes to req_n or req_valid after acceptance are ignored.
  - A requester may drop req_valid before grant.
- Overflow tracking:
  - b may overflow while a is still exact. Example: n=30, W=20 gives a=832040 exact, b=F(31) overflowed.
  - Therefore resp_ovf reflects a only.
- Fairness: a requester holding req_valid waits at most NREQ-1 other transactions.
- Unused index: NREQ < 2^IDW is legal; unused IDs are never granted.

Optional Feature:
- Macro FIB_SAT_EN.
- Defined: when ovf_a=1, resp_data={W{1'b1}} (saturated).
- Undefined: resp_data is F(n) mod 2^W.
- resp_ovf behaves identically in both builds.

Test Plan:
- Single request, req 0, n=5, resp_ready=1: accepted → resp_valid rises 6 clocks later with resp_data=5, resp_id=0, resp_ovf=0. Repeat with n=0 (result 0, latency 1) and n=1 (result 1, latency 2).
- Boundary n=30 then n=31, W=20:
  - n=30 → 832040, ovf=0.
  - n=31 → ovf=1; resp_data=297693 without FIB_SAT_EN, 1048575 with it.
  - n=255 → ovf=1.
- All four requesters valid continuously, n=3,4,6,7 for ids 0..3: grants and responses in id order 0,1,2,3,0; results 2,3,8,13; never two req_ready bits high.
- Backpressure: n=10, resp_ready=0 for 20 cycles after resp_valid: resp_data=55 and resp_id held stable, req_ready stays 0; then resp_ready=1 → IDLE next cycle.
- Reset pulse asserted asynchronously mid-RUN (n=20, after 5 iterations): all outputs 0 immediately, no response emitted; a fresh n=2 request then returns 1 with RR pointer back at 0.
- Input change after acceptance: change req_n[0] from 8 to 12 one cycle after grant → response is 21 (F(8)).
